// File: rtl/fifo_rr_scheduler.sv
// Round-robin write arbiter feeding a shared FIFO, plus a three-state read
// sequencer that hides the FIFO's registered read port from the consumer.
module fifo_rr_scheduler #(
    parameter int  data_width = 16,
    parameter int  num_req    = 4,
    localparam int src_bits   = (num_req > 1) ? $clog2(num_req) : 1
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [num_req-1:0]             req,
    input  logic [num_req*data_width-1:0]  req_data,
    output logic [num_req-1:0]             req_ack,
    output logic                           fifo_wr_en,
    output logic [data_width+src_bits-1:0] fifo_din,
    input  logic                           fifo_full,
    input  logic                           fifo_empty,
    input  logic [data_width+src_bits-1:0] fifo_dout,
    output logic                           fifo_rd_en,
    output logic                           out_valid,
    output logic [data_width-1:0]          out_data,
    output logic [src_bits-1:0]            out_src,
    input  logic                           out_ready
);

    typedef logic [src_bits:0] cand_t;
    typedef enum logic [1:0] {IDLE, WAIT, VALID} state_t;

    logic [data_width-1:0] lane_data [num_req];
    logic [src_bits-1:0]   last_grant_reg;
    logic [src_bits-1:0]   grant_idx;
    logic                  grant_found;
    logic                  grant_ok;
    cand_t                 cand;

    state_t                state_reg, state_next;
    logic                  capture;
    logic [data_width-1:0] out_data_reg;
    logic [src_bits-1:0]   out_src_reg;

    genvar gi;
    generate
        for (gi = 0; gi < num_req; gi++) begin : g_lane
            assign lane_data[gi] = req_data[gi*data_width +: data_width];
        end
    endgenerate

    // Search starts one past the previous winner and wraps modulo num_req.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int k = 1; k <= num_req; k++) begin
            cand = {1'b0, last_grant_reg} + cand_t'(k);
            if (cand >= cand_t'(num_req)) begin
                cand = cand - cand_t'(num_req);
            end
            if (!grant_found && req[cand[src_bits-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = cand[src_bits-1:0];
            end
        end
    end

    // Gating with rst_n keeps the combinational write side quiet during reset.
    assign grant_ok = rst_n && !fifo_full && grant_found;

    always_comb begin
        req_ack    = '0;
        fifo_wr_en = 1'b0;
        fifo_din   = '0;
        if (grant_ok) begin
            req_ack[grant_idx] = 1'b1;
            fifo_wr_en         = 1'b1;
            fifo_din           = {grant_idx, lane_data[grant_idx]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_reg <= src_bits'(num_req - 1);
        end else if (grant_ok) begin
            last_grant_reg <= grant_idx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // WAIT exists only so the FIFO's registered dout has caught up with its head.
    always_comb begin
        state_next = state_reg;
        out_valid  = 1'b0;
        fifo_rd_en = 1'b0;
        capture    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (!fifo_empty) begin
                    state_next = WAIT;
                end
            end
            WAIT: begin
                capture    = 1'b1;
                state_next = VALID;
            end
            VALID: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    fifo_rd_en = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data_reg <= '0;
            out_src_reg  <= '0;
        end else if (capture) begin
            out_data_reg <= fifo_dout[data_width-1:0];
            out_src_reg  <= fifo_dout[data_width +: src_bits];
        end
    end

    assign out_data = out_data_reg;
    assign out_src  = out_src_reg;

endmodule

// File: tb/tb_fifo_rr_scheduler.sv
// Directed bench: the scheduler drives a small behavioural FIFO (depth 4,
// registered head read) and each step is compared to hand-derived values.
module tb_fifo_rr_scheduler;

    localparam int data_width = 16;
    localparam int num_req    = 4;
    localparam int src_bits   = 2;
    localparam int fw         = data_width + src_bits;
    localparam int depth      = 4;

    logic                          clk = 1'b0;
    logic                          rst_n;
    logic [num_req-1:0]            req;
    logic [num_req*data_width-1:0] req_data;
    logic [num_req-1:0]            req_ack;
    logic                          fifo_wr_en;
    logic [fw-1:0]                 fifo_din;
    logic                          fifo_full;
    logic                          fifo_empty;
    logic [fw-1:0]                 fifo_dout;
    logic                          fifo_rd_en;
    logic                          out_valid;
    logic [data_width-1:0]         out_data;
    logic [src_bits-1:0]           out_src;
    logic                          out_ready;

    int num_checks = 0;
    int num_errors = 0;

    always #5 clk = ~clk;

    fifo_rr_scheduler #(.data_width(data_width), .num_req(num_req)) dut (
        .clk(clk), .rst_n(rst_n),
        .req(req), .req_data(req_data), .req_ack(req_ack),
        .fifo_wr_en(fifo_wr_en), .fifo_din(fifo_din),
        .fifo_full(fifo_full), .fifo_empty(fifo_empty),
        .fifo_dout(fifo_dout), .fifo_rd_en(fifo_rd_en),
        .out_valid(out_valid), .out_data(out_data), .out_src(out_src),
        .out_ready(out_ready)
    );

    // Behavioural FIFO: dout registers the current head every cycle.
    logic [fw-1:0] fifo_mem [depth];
    logic [1:0]    wr_ptr, rd_ptr;
    logic [2:0]    count;
    logic          wr_ok, rd_ok;
    int            overflow_cnt  = 0;
    int            underflow_cnt = 0;

    assign fifo_full  = (count == 3'(depth));
    assign fifo_empty = (count == 3'd0);
    assign wr_ok      = fifo_wr_en && !fifo_full;
    assign rd_ok      = fifo_rd_en && !fifo_empty;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            fifo_dout <= '0;
        end else begin
            fifo_dout <= fifo_mem[rd_ptr];
            if (fifo_wr_en && fifo_full) overflow_cnt <= overflow_cnt + 1;
            if (fifo_rd_en && fifo_empty) underflow_cnt <= underflow_cnt + 1;
            if (wr_ok) begin
                fifo_mem[wr_ptr] <= fifo_din;
                wr_ptr           <= wr_ptr + 2'd1;
            end
            if (rd_ok) rd_ptr <= rd_ptr + 2'd1;
            count <= count + 3'(wr_ok) - 3'(rd_ok);
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        num_checks++;
        if (got !== exp) begin
            num_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    logic [3:0]    exp_ack [13];
    logic [fw-1:0] exp_out [4];
    int            pulses;
    int            acks;

    initial begin
        exp_ack = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0000, 4'b0000,
                    4'b0010, 4'b0000, 4'b0000, 4'b0100, 4'b0000, 4'b0000};
        exp_out = '{18'h000A0, 18'h100A1, 18'h200A2, 18'h300A3};

        rst_n     = 1'b1;
        req       = 4'b1111;
        req_data  = {16'h00A3, 16'h00A2, 16'h00A1, 16'h00A0};
        out_ready = 1'b1;

        // Reset asserted mid-cycle with every lane requesting.
        #2 rst_n = 1'b0;
        #1;
        check_eq("rst_ack", 32'(req_ack), 32'h0);
        check_eq("rst_wr_en", 32'(fifo_wr_en), 32'h0);
        check_eq("rst_din", 32'(fifo_din), 32'h0);
        check_eq("rst_valid", 32'(out_valid), 32'h0);
        check_eq("rst_rd_en", 32'(fifo_rd_en), 32'h0);
        check_eq("rst_out", 32'({out_src, out_data}), 32'h0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;

        // Fairness, in-order output, 3-cycle latency, full stall with read in flight.
        for (int c = 0; c < 13; c++) begin
            @(negedge clk);
            check_eq($sformatf("fair_ack_c%0d", c), 32'(req_ack), 32'(exp_ack[c]));
            check_eq($sformatf("fair_valid_c%0d", c), 32'(out_valid), 32'((c % 3 == 0) && c > 0));
            check_eq($sformatf("fair_rd_c%0d", c), 32'(fifo_rd_en), 32'((c % 3 == 0) && c > 0));
            if ((c % 3 == 0) && c > 0)
                check_eq($sformatf("fair_out_c%0d", c), 32'({out_src, out_data}), 32'(exp_out[c/3 - 1]));
            if (c == 3 || c == 4)
                check_eq($sformatf("rw_depth_c%0d", c), 32'(count), 32'd3);
        end

        // Reset mid-operation drops the word held in VALID.
        #1 rst_n = 1'b0;
        #1;
        check_eq("midrst_valid", 32'(out_valid), 32'h0);
        check_eq("midrst_ack", 32'(req_ack), 32'h0);
        check_eq("midrst_wr_en", 32'(fifo_wr_en), 32'h0);
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        check_eq("first_grant_lane0", 32'(req_ack), 32'b0001);
        @(posedge clk); #1 req = 4'b0100;
        @(negedge clk);
        check_eq("grant_lane2", 32'(req_ack), 32'b0100);
        @(posedge clk); #1 req = 4'b0011;
        @(negedge clk);
        check_eq("wrap_lane0", 32'(req_ack), 32'b0001);
        @(posedge clk); #1;
        @(negedge clk);
        check_eq("skip_lane1", 32'(req_ack), 32'b0010);
        check_eq("hold_first_valid", 32'(out_valid), 32'h1);
        check_eq("hold_first_out", 32'({out_src, out_data}), 32'h000A0);
        @(negedge clk);
        check_eq("full_flag", 32'(fifo_full), 32'h1);
        check_eq("full_no_ack", 32'(req_ack), 32'h0);

        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check_eq($sformatf("hold_data_%0d", i), 32'(out_data), 32'h00A0);
            check_eq($sformatf("hold_rd_%0d", i), 32'(fifo_rd_en), 32'h0);
            check_eq($sformatf("hold_ack_%0d", i), 32'(req_ack), 32'h0);
        end

        @(posedge clk); #1 out_ready = 1'b1;
        pulses = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            pulses += int'(fifo_rd_en);
            if (i == 0) check_eq("boundary_no_ack", 32'(req_ack), 32'h0);
            if (i == 1) check_eq("boundary_ack", 32'(req_ack), 32'b0001);
        end
        check_eq("rd_pulses", 32'(pulses), 32'd1);

        // Single lane pushing into a stalled consumer until full.
        @(posedge clk); #1;
        rst_n     = 1'b0;
        out_ready = 1'b0;
        req       = 4'b0010;
        @(posedge clk); #2 rst_n = 1'b1;
        acks = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (req_ack == 4'b0010) acks++;
        end
        check_eq("bp_ack_count", 32'(acks), 32'd4);
        check_eq("bp_ack_idle", 32'(req_ack), 32'h0);
        check_eq("bp_full", 32'(fifo_full), 32'h1);
        check_eq("bp_valid", 32'(out_valid), 32'h1);
        check_eq("bp_out", 32'({out_src, out_data}), 32'h100A1);
        check_eq("overflow", 32'(overflow_cnt), 32'd0);
        check_eq("underflow", 32'(underflow_cnt), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
        $finish;
    end

endmodule

// File: doc/fifo_rr_scheduler.md
# fifo_rr_scheduler

Round-robin scheduler that shares one `fifo` instance between `num_req` producer lanes of the cofactor datapath and drains it to a single consumer through a valid/ready interface. Each accepted word is tagged with its source lane index before storage. The block sits between the lane engines and the shared FIFO. The FIFO is instantiated externally with `data_width = data_width + src_bits`, where `src_bits = $clog2(num_req)`, minimum 1. The block owns every `wr_en`/`rd_en` decision and compensates for the FIFO's registered read port.

## Interface
- `data_width`, default 16: payload width per lane.
- `num_req`, default 4: number of producer lanes, 2..16.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req` in num_req: lane i holds a word to write.
- `req_data` in num_req*data_width: lane i payload in bits [i*data_width +: data_width].
- `req_ack` out num_req: one-hot; lane i's word is accepted this cycle.
- `fifo_wr_en` out 1: to FIFO `wr_en`.
- `fifo_din` out data_width+src_bits: to FIFO `din`, packed as {src, payload}.
- `fifo_full` in 1: from FIFO `full`.
- `fifo_empty` in 1: from FIFO `empty`.
- `fifo_dout` in data_width+src_bits: from FIFO `dout`.
- `fifo_rd_en` out 1: to FIFO `rd_en`.
- `out_valid` out 1: output word valid.
- `out_data` out data_width: output payload.
- `out_src` out src_bits: lane index of the output word.
- `out_ready` in 1: consumer accepts the word.

## Operation
- **Write arbiter** (combinational grant, registered pointer `last_grant`)
  - Search order per cycle is `last_grant+1`, `last_grant+2`, …, wrapping modulo `num_req`. The first lane with `req[i]=1` wins.
  - If `fifo_full=1`, nothing is granted: `req_ack=0` and `fifo_wr_en=0`. The block never writes while full, even when a read is in flight.
  - When a grant occurs: `req_ack[g]=1`, `fifo_wr_en=1`, `fifo_din={g, payload_g}`, and `last_grant<=g` at the clock edge.
  - When nothing is granted, `fifo_din=0` and `last_grant` holds.
  - Lanes must hold `req`/`req_data` stable until they receive an ack. A lane that drops `req` without an ack is simply skipped.
- **Read FSM**, states IDLE, WAIT, VALID:
  - IDLE: when `fifo_empty=0`, go to WAIT.
  - WAIT: one cycle, which covers the FIFO's registered `dout`. At exit, `out_data`/`out_src` <= `fifo_dout`. Go to VALID.
  - VALID: `out_valid=1`. When `out_ready=1`, pulse `fifo_rd_en=1` for that cycle only and go to IDLE. Otherwise hold, with `out_data`/`out_src` stable.
  - `fifo_rd_en` is asserted only in VALID with `out_ready=1`. An empty FIFO is therefore never read.
- The read side and write side run independently. A write and a read may occur in the same cycle.

## Timing
- **Reset** (`rst_n=0`, asynchronous) forces:
  - FSM to IDLE;
  - `last_grant = num_req-1`, so lane 0 has top priority after reset;
  - `out_valid=0`, `out_data=0`, `out_src=0`, `fifo_rd_en=0`.
- `req_ack`, `fifo_wr_en` and `fifo_din` are combinational. All three are 0 while `rst_n=0`.
- **Reset mid-operation**:
  - a word held in VALID is discarded;
  - the FIFO must be reset together with this block. Sharing `rst_n` through an inverter to `rst` is acceptable.
- **Write throughput**: one word per cycle while not full.
- **Write-to-output latency**:
  - write edge at t: `fifo_empty` falls after t;
  - IDLE→WAIT at edge t+1;
  - `out_valid` rises after edge t+2.
- **Read throughput**: one word per 3 cycles (IDLE, WAIT, VALID) with `out_ready` held high.
- **Full boundary**: once `fifo_full=1`, the next grant occurs in the cycle after a `fifo_rd_en` edge lowers the depth.
- **Pointer wrap**: `last_grant=num_req-1` searches from lane 0.

## Test plan
- **Reset values**: assert `rst_n=0` mid-cycle with `req=4'b1111`. Require immediately `out_valid=0`, `req_ack=0` and `fifo_wr_en=0`. After release, the first grant goes to lane 0.
- **Fairness**: hold `req=4'b1111` with payloads 0xA0..0xA3 and `out_ready=1`. Required results:
  - acks on lanes 0,1,2,3,0,… on consecutive cycles;
  - outputs in order (src 0, 0xA0), (1, 0xA1), (2, 0xA2), (3, 0xA3);
  - `out_valid` first high 3 cycles after the first ack.
- **Wrap/skip**: `last_grant=2` with `req=4'b0011` → lane 0 is acked first, then lane 1.
- **Full backpressure**: `fifo_bit=2` (depth 4), `out_ready=0`, lane 1 requesting continuously. Required results:
  - exactly 4 acks, then `req_ack=0` while `fifo_full=1`;
  - no FIFO overflow error message;
  - `out_valid=1` with src 1.
- **Hold**: `out_ready=0` for 10 cycles in VALID → `out_data` constant and `fifo_rd_en=0`. Raising `out_ready` gives exactly one `fifo_rd_en` pulse.
- **Simultaneous read and write**: while the FIFO is not full, an ack and a `fifo_rd_en` land in the same cycle. Depth is unchanged, and the next output is the next-oldest word.
